truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Parametrised, clocked successor to the 2-input gate cells. It walks all 2^N_IN input combinations in order and drives each vector plus the selected gate's result on registered outputs. It replaces hand-written truth-table stimulus in day-exercise benches and serves as a reusable gate-sweep engine. One sweep per start pulse, with stall (hold) support and a done pulse.

Parameters:
N_IN, 2, number of gate inputs; legal range 1..8.
OP_W, 3, width of the op select.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
op  input  OP_W  gate select; latched when start is accepted
hold  input  1  stall; freezes the sweep while high
in_vec  output  N_IN  current input combination
gate_out  output  1  gate result for in_vec
valid  output  1  in_vec/gate_out pair is a new truth-table row this cycle
busy  output  1  sweep in progress
done  output  1  one-cycle pulse after the last row

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; in_vec=0, gate_out=0, valid=0, busy=0, done=0, op_q=0, idx=0.
- Reset mid-sweep aborts the sweep immediately at that edge. All outputs return to reset values and no done pulse is issued.
- Op encoding (op_q applied as a reduction over in_vec):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 BUF (in_vec[0]), 7 NOT (~in_vec[0])
  - All 8 codes are legal.
- FSM has two states, IDLE and SWEEP.
- IDLE:
  - done<=0.
  - If start=1: op_q<=op, in_vec<=0, gate_out<=f(op,0), valid<=1, idx<=1, busy<=1, state<=SWEEP.
  - hold is ignored in IDLE.
- SWEEP, with hold=1: in_vec, gate_out, idx unchanged; valid<=0.
- SWEEP, with hold=0 and in_vec != all-ones:
  - in_vec<=idx, gate_out<=f(op_q,idx), valid<=1, idx<=idx+1.
- SWEEP, with hold=0 and in_vec == all-ones (last row already presented):
  - valid<=0, busy<=0, done<=1, state<=IDLE.
  - in_vec and gate_out keep the last row.
- Latency: start accepted at edge E gives the first row at E (visible in the cycle after start).
- Throughput: with no hold, row k is valid k cycles later. done asserts 2^N_IN edges after E.
- Row rules: each row is valid for exactly one cycle. No row is skipped or repeated across hold.
- Width rules:
  - idx is N_IN+1 bits, so no wrap at N_IN=8.
  - Last-row detection compares in_vec against all-ones, never idx.
- start while busy: ignored; op changes mid-sweep have no effect.
- start in the done cycle: state is already IDLE, so it is accepted and a new sweep begins back-to-back.
- N_IN=1: exactly 2 rows.

Optional Feature:
Macro TT_CAPTURE_EN.
- Defined: adds output tt_word [2**N_IN-1:0].
  - Cleared to 0 when start is accepted and on reset.
  - Bit k <= gate_out result whenever row k is valid.
  - Stable and complete from the done pulse until the next accepted start.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared header gate_defs.vh holds:
  - op-code localparams OP_AND..OP_NOT
  - OP_W
  - state encodings ST_IDLE/ST_SWEEP
- Sub-module gate_eval (combinational): N_IN-bit vector plus op gives a 1-bit result. It is instantiated once and also reused by the bench as its reference model.

Test Plan:
1. N_IN=2, op=AND, start one cycle, hold=0 -> rows 00/0, 01/0, 10/0, 11/1 on 4 consecutive valid cycles; done pulses on the 5th cycle; busy high for 4 cycles.
2. N_IN=3, op=XOR, hold=1 for 2 cycles after row 3 -> row 3 (011/0) valid once; valid=0 for 2 cycles; then row 4 (100/1). All 8 rows are seen exactly once and done follows row 7 (111/1).
3. N_IN=2, op=NOR, then op=AND and start=1 pulsed during the sweep -> NOR results 1,0,0,0 unchanged; no restart; single done.
4. N_IN=2, rst asserted after row 1 -> next cycle valid=0, busy=0, in_vec=00, done never asserts; a new start then gives a clean 4-row sweep.
5. N_IN=1, op=NOT, start held high continuously -> rows 0/1, 1/0, done, then a new sweep begins the cycle after done's edge, repeating.
6. TT_CAPTURE_EN defined, N_IN=3, op=NAND -> tt_word=8'b0111_1111 at done; tt_word reads 0 one cycle after the next accepted start.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: op codes, default op width, FSM states.
// Latency: none (definitions only).
// Backpressure: n/a.
package truth_table_sweeper_pkg;

    localparam int OP_W_DEF = 3;

    // Gate select codes, applied as a reduction over the input vector.
    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;
    localparam int OP_BUF  = 6;
    localparam int OP_NOT  = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_gate_eval.sv
// Combinational N-input gate: reduces vec with the operation selected by op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; unknown op codes (only possible with OP_W > 3) yield 0.
module gate_eval
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int OP_W = OP_W_DEF
) (
    input  logic [N_IN-1:0] vec,
    input  logic [OP_W-1:0] op,
    output logic            res
);

    // Select the reduction; BUF/NOT look only at bit 0.
    always_comb begin
        res = 1'b0;
        case (int'(op))
            OP_AND:  res = &vec;
            OP_OR:   res = |vec;
            OP_XOR:  res = ^vec;
            OP_NAND: res = ~&vec;
            OP_NOR:  res = ~|vec;
            OP_XNOR: res = ~^vec;
            OP_BUF:  res = vec[0];
            OP_NOT:  res = ~vec[0];
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 2^N_IN input vectors once per start, presenting each with its gate result (TT_CAPTURE_EN adds tt_word).
// Latency: first row registered at the start-accept edge; one row per un-held cycle; done 2^N_IN edges after start.
// Backpressure: hold freezes the sweep (valid drops, row and index kept); start ignored while busy.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            hold,
    output logic [N_IN-1:0] in_vec,
    output logic            gate_out,
    output logic            valid,
    output logic            busy,
    output logic            done
`ifdef TT_CAPTURE_EN
    ,
    output logic [2**N_IN-1:0] tt_word
`endif
);

    // Last-row detection looks at the presented vector, so idx may run one past the top.
    localparam logic [N_IN-1:0] LAST_ROW = '1;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [N_IN-1:0] in_vec_d;
    logic            gate_out_d;
    logic            valid_d;
    logic            busy_d;
    logic            done_d;

    logic [N_IN-1:0] eval_vec;
    logic [OP_W-1:0] eval_op;
    logic            eval_res;

    logic            start_acc;

    assign start_acc = (state_q == ST_IDLE) && start;

    // One shared evaluator: row 0 with the live op at start, else the next row with the latched op.
    always_comb begin
        eval_vec = '0;
        eval_op  = op;
        if (state_q == ST_SWEEP) begin
            eval_vec = idx_q[N_IN-1:0];
            eval_op  = op_q;
        end
    end

    gate_eval #(
        .N_IN (N_IN),
        .OP_W (OP_W)
    ) u_gate_eval (
        .vec (eval_vec),
        .op  (eval_op),
        .res (eval_res)
    );

    // Next-state and next-output logic for the two-state sweep FSM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        in_vec_d   = in_vec;
        gate_out_d = gate_out;
        valid_d    = valid;
        busy_d     = busy;
        done_d     = done;
        case (state_q)
            ST_IDLE: begin
                done_d  = 1'b0;
                valid_d = 1'b0;
                if (start) begin
                    op_d       = op;
                    in_vec_d   = '0;
                    gate_out_d = eval_res;
                    valid_d    = 1'b1;
                    idx_d      = (N_IN+1)'(1);
                    busy_d     = 1'b1;
                    state_d    = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (hold) begin
                    valid_d = 1'b0;
                end else if (in_vec != LAST_ROW) begin
                    in_vec_d   = idx_q[N_IN-1:0];
                    gate_out_d = eval_res;
                    valid_d    = 1'b1;
                    idx_d      = idx_q + 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered row outputs, latched op and row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            idx_q    <= '0;
            in_vec   <= '0;
            gate_out <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            op_q     <= op_d;
            idx_q    <= idx_d;
            in_vec   <= in_vec_d;
            gate_out <= gate_out_d;
            valid    <= valid_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

`ifdef TT_CAPTURE_EN
    // Capture each valid row's result into its bit; cleared on accepted start so it is complete at done.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_word <= '0;
        end else if (start_acc) begin
            tt_word <= '0;
        end else if (valid) begin
            tt_word[in_vec] <= gate_out;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: N_IN=3 instance against a row-level reference model, N_IN=1 instance with literals.
// Latency: model updates on each rising edge; outputs compared on the falling edge.
// Backpressure: random hold/start/reset patterns exercise stalls, ignored starts and aborts.
module tb_truth_table_sweeper;

    localparam int N = 3;
    localparam int NROWS = 1 << N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals (N_IN=3).
    logic         rst = 1'b1, start = 1'b0, hold = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [N-1:0] in_vec;
    logic         gate_out, valid, busy, done;
`ifdef TT_CAPTURE_EN
    logic [NROWS-1:0] tt_word;
`endif

    // Second instance (N_IN=1).
    logic       rst1 = 1'b1, start1 = 1'b0, hold1 = 1'b0;
    logic [2:0] op1 = 3'd0;
    logic [0:0] in_vec1;
    logic       gate_out1, valid1, busy1, done1;
`ifdef TT_CAPTURE_EN
    logic [1:0] tt_word1;
`endif

    truth_table_sweeper #(.N_IN(N), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .hold(hold),
        .in_vec(in_vec), .gate_out(gate_out), .valid(valid), .busy(busy), .done(done)
`ifdef TT_CAPTURE_EN
        , .tt_word(tt_word)
`endif
    );

    truth_table_sweeper #(.N_IN(1), .OP_W(3)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .op(op1), .hold(hold1),
        .in_vec(in_vec1), .gate_out(gate_out1), .valid(valid1), .busy(busy1), .done(done1)
`ifdef TT_CAPTURE_EN
        , .tt_word(tt_word1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Gate truth from the definition of each op, via the count of ones.
    function automatic logic ref_gate(input int opc, input int v, input int n);
        int pop;
        pop = 0;
        for (int b = 0; b < n; b++) pop += (v >> b) & 1;
        case (opc)
            0: return pop == n;
            1: return pop > 0;
            2: return (pop % 2) == 1;
            3: return pop != n;
            4: return pop == 0;
            5: return (pop % 2) == 0;
            6: return (v & 1) == 1;
            default: return (v & 1) == 0;
        endcase
    endfunction

    // Row-level reference model: which row is showing, whether it is fresh, sweep progress.
    int               m_row = 0;
    int               m_op = 0;
    logic             m_gate = 0, m_valid = 0, m_busy = 0, m_done = 0;
    logic [NROWS-1:0] m_tt = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_row = 0; m_op = 0; m_gate = 0; m_valid = 0; m_busy = 0; m_done = 0; m_tt = '0;
        end else begin
            if (m_valid) m_tt[m_row] = m_gate;
            if (!m_busy) begin
                m_done  = 0;
                m_valid = 0;
                if (start) begin
                    m_op = int'(op); m_row = 0; m_gate = ref_gate(m_op, 0, N);
                    m_valid = 1; m_busy = 1; m_tt = '0;
                end
            end else if (hold) begin
                m_valid = 0;
            end else if (m_row == NROWS - 1) begin
                m_valid = 0; m_busy = 0; m_done = 1;
            end else begin
                m_row = m_row + 1;
                m_gate = ref_gate(m_op, m_row, N);
                m_valid = 1;
            end
        end
    end

    // Per-cycle comparison of the main instance against the model, plus a rows-per-sweep scoreboard.
    logic cmp_en = 1'b0;
    int   rows_seen = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", valid, m_valid);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("in_vec", in_vec, m_row[N-1:0]);
            chk("gate_out", gate_out, m_gate);
`ifdef TT_CAPTURE_EN
            chk("tt_word", tt_word, m_tt);
`endif
            if (valid === 1'b1) begin
                if (in_vec == '0) rows_seen = 1;
                else rows_seen++;
            end
            if (done === 1'b1) chk("rows_per_sweep", rows_seen, NROWS);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic row(input string nm, input int v, input logic g);
        chk({nm, "_valid"}, valid, 1'b1);
        chk({nm, "_vec"}, in_vec, v[N-1:0]);
        chk({nm, "_gate"}, gate_out, g);
    endtask

    initial begin
        // N_IN=1, NOT, start held high: rows 0/1, 1/0, done, repeating.
        rst1 = 1'b1; tick(); tick();
        chk("n1_reset_valid", valid1, 1'b0);
        chk("n1_reset_busy", busy1, 1'b0);
        rst1 = 1'b0; op1 = 3'd7; start1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            case (c % 3)
                0: begin
                    chk("n1_r0_valid", valid1, 1'b1); chk("n1_r0_vec", in_vec1, 1'b0);
                    chk("n1_r0_gate", gate_out1, 1'b1); chk("n1_r0_done", done1, 1'b0);
                end
                1: begin
                    chk("n1_r1_valid", valid1, 1'b1); chk("n1_r1_vec", in_vec1, 1'b1);
                    chk("n1_r1_gate", gate_out1, 1'b0);
                end
                default: begin
                    chk("n1_done", done1, 1'b1); chk("n1_done_valid", valid1, 1'b0);
                    chk("n1_done_busy", busy1, 1'b0);
                end
            endcase
        end
        start1 = 1'b0;

        // Main instance reset state.
        rst = 1'b1; tick(); tick();
        cmp_en = 1'b1;
        chk("reset_vec", in_vec, 3'd0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;

        // XOR sweep with a two-cycle hold after row 3.
        op = 3'd2; start = 1'b1; tick(); start = 1'b0;
        row("xor_r0", 0, 1'b0);
        tick(); row("xor_r1", 1, 1'b1);
        tick(); tick(); row("xor_r3", 3, 1'b0);
        hold = 1'b1; tick();
        chk("xor_hold_valid", valid, 1'b0);
        chk("xor_hold_vec", in_vec, 3'd3);
        tick(); hold = 1'b0; tick();
        row("xor_r4", 4, 1'b1);
        tick(); tick(); tick();
        row("xor_r7", 7, 1'b1);
        tick();
        chk("xor_done", done, 1'b1);
        chk("xor_done_busy", busy, 1'b0);
        chk("xor_done_vec", in_vec, 3'd7);
        tick();
        chk("xor_done_pulse", done, 1'b0);

        // NOR sweep with op change and start pulse mid-sweep: ignored.
        op = 3'd4; start = 1'b1; tick(); start = 1'b0; op = 3'd0;
        row("nor_r0", 0, 1'b1);
        tick(); row("nor_r1", 1, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        row("nor_r2", 2, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        row("nor_r7", 7, 1'b0);
        tick(); chk("nor_done", done, 1'b1);
        tick();

        // Reset mid-sweep aborts with no done; then a clean sweep.
        op = 3'd1; start = 1'b1; tick(); start = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_valid", valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_vec", in_vec, 3'd0);
        for (int i = 0; i < 4; i++) tick();
        op = 3'd0; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Random start/op/hold with occasional reset, checked by the model.
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            hold  = ($urandom_range(0, 9) < 3);
            tick();
        end
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        for (int i = 0; i < 12; i++) tick();

`ifdef TT_CAPTURE_EN
        // NAND capture: complete word at done, cleared after the next accepted start.
        op = 3'd3; start = 1'b1; tick(); start = 1'b0;
        chk("tt_cleared", tt_word, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        chk("tt_nand_done", done, 1'b1);
        chk("tt_nand_word", tt_word, 8'h7F);
        tick();
        chk("tt_hold_word", tt_word, 8'h7F);
        op = 3'd1; start = 1'b1; tick(); start = 1'b0;
        chk("tt_restart_clear", tt_word, 8'h00);
        for (int i = 0; i < 10; i++) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
